// File: rtl/vseq_ctrl.sv
// Vector pass sequencer: splits a vector instruction of up to MAXLEN elements
// into LANES-wide passes, stalling fetch and driving vregfile group/mask/write enable.
module vseq_ctrl #(
  parameter int LANES  = 5,
  parameter int MAXLEN = 20,
  parameter int GW     = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      Instr,
  input  logic             RegWrite,
  input  logic             flush,
  output logic             stall,
  output logic             vwe,
  output logic [GW-1:0]    group,
  output logic [LANES-1:0] lane_mask,
  output logic             busy,
  output logic             done,
  output logic             len_err,
  output logic [0:0]       dbg_state
);

  // Handshake: there is no valid/ready pair here; stall=1 means "hold PC and
  // Instr this cycle", and the instruction is consumed on the edge where stall=0.

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]    state;
  logic [GW-1:0] cnt;
  logic [4:0]    len_q;
  logic          we_q;

  logic          vector_op;
  logic [4:0]    len;
  logic [4:0]    len_clamp;
  logic [4:0]    cur_len;
  logic [GW-1:0] cur_grp;
  logic [7:0]    offset;
  logic [7:0]    rem;
  logic          last;
  logic          start;

  function automatic logic [LANES-1:0] mask_of(input logic [7:0] r);
    logic [LANES-1:0] m;
    for (int i = 0; i < LANES; i++) m[i] = (8'(i) < r);
    return m;
  endfunction

  assign vector_op = (Instr[31:28] == 4'b1111);
  assign len       = Instr[8:4];
  assign len_clamp = (len > 5'(MAXLEN)) ? 5'(MAXLEN) : len;
  assign start     = vector_op && (len != 5'd0);

  // Elements remaining from the current group onward; cnt never passes the
  // last group, so this cannot underflow.
  assign cur_len = (state == S_RUN) ? len_q : len_clamp;
  assign cur_grp = (state == S_RUN) ? cnt : '0;
  assign offset  = 8'(32'(cur_grp) * LANES);
  assign rem     = {3'b000, cur_len} - offset;
  assign last    = (rem <= 8'(LANES));

  always_comb begin
    stall     = 1'b0;
    vwe       = 1'b0;
    group     = '0;
    lane_mask = '0;
    busy      = 1'b0;
    done      = 1'b0;
    len_err   = 1'b0;
    dbg_state = reset ? state : S_IDLE;
    if (reset) begin
      case (state)
        S_IDLE: begin
          if (start) begin
            vwe       = RegWrite;
            lane_mask = mask_of(rem);
            len_err   = (len > 5'(MAXLEN));
            stall     = !last;
            done      = last;
          end
        end
        S_RUN: begin
          busy      = 1'b1;
          group     = cnt;
          lane_mask = mask_of(rem);
          if (!flush) begin
            vwe   = we_q;
            stall = !last;
            done  = last;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      len_q <= '0;
      we_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !last) begin
            state <= S_RUN;
            len_q <= len_clamp;
            we_q  <= RegWrite;
            cnt   <= GW'(1);
          end
        end
        S_RUN: begin
          if (flush || last) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vseq_ctrl.sv
// Directed bench for vseq_ctrl: hand-computed per-cycle output vectors
// packed as {stall, vwe, group[1:0], lane_mask[4:0], busy, done, len_err}.
module tb_vseq_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] Instr;
  logic        RegWrite;
  logic        flush;
  logic        stall;
  logic        vwe;
  logic [1:0]  group;
  logic [4:0]  lane_mask;
  logic        busy;
  logic        done;
  logic        len_err;
  logic [0:0]  dbg_state;

  int n_checks = 0;
  int n_err    = 0;

  vseq_ctrl #(.LANES(5), .MAXLEN(20), .GW(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .Instr     (Instr),
    .RegWrite  (RegWrite),
    .flush     (flush),
    .stall     (stall),
    .vwe       (vwe),
    .group     (group),
    .lane_mask (lane_mask),
    .busy      (busy),
    .done      (done),
    .len_err   (len_err),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] vinstr(input logic [4:0] l);
    return {4'hF, 19'h0, l, 4'h0};
  endfunction

  function automatic logic [31:0] sinstr(input logic [4:0] l);
    return {4'hE, 19'h0, l, 4'h0};
  endfunction

  function automatic logic [11:0] ev(input logic s, input logic v, input logic [1:0] g,
                                     input logic [4:0] m, input logic b, input logic d,
                                     input logic e);
    return {s, v, g, m, b, d, e};
  endfunction

  function automatic logic [11:0] obs();
    return {stall, vwe, group, lane_mask, busy, done, len_err};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver: apply inputs mid-low phase, then check combinational outputs
  task automatic step(input string tag, input logic [31:0] ins, input logic rw,
                      input logic fl, input logic [11:0] exp);
    @(negedge clk);
    Instr    = ins;
    RegWrite = rw;
    flush    = fl;
    #1;
    chk(tag, 32'(obs()), 32'(exp));
  endtask

  initial begin
    reset    = 1'b0;
    Instr    = vinstr(5'd20);
    RegWrite = 1'b1;
    flush    = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outs", 32'(obs()), 32'h0);
    chk("reset_state", 32'(dbg_state), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    Instr = sinstr(5'd3);

    step("scalar", sinstr(5'd3), 1'b1, 1'b0, 12'h0);
    chk("scalar_state", 32'(dbg_state), 32'h0);

    step("len3", vinstr(5'd3), 1'b1, 1'b0, ev(0, 1, 2'd0, 5'b00111, 0, 1, 0));
    step("len3_next", sinstr(5'd0), 1'b1, 1'b0, 12'h0);

    step("len0", vinstr(5'd0), 1'b1, 1'b0, 12'h0);

    step("len5", vinstr(5'd5), 1'b1, 1'b0, ev(0, 1, 2'd0, 5'b11111, 0, 1, 0));

    step("len6_c1", vinstr(5'd6), 1'b1, 1'b0, ev(1, 1, 2'd0, 5'b11111, 0, 0, 0));
    step("len6_c2", vinstr(5'd6), 1'b1, 1'b0, ev(0, 1, 2'd1, 5'b00001, 1, 1, 0));

    step("len12_c1", vinstr(5'd12), 1'b1, 1'b0, ev(1, 1, 2'd0, 5'b11111, 0, 0, 0));
    step("len12_c2", vinstr(5'd12), 1'b1, 1'b0, ev(1, 1, 2'd1, 5'b11111, 1, 0, 0));
    step("len12_c3", vinstr(5'd12), 1'b1, 1'b0, ev(0, 1, 2'd2, 5'b00011, 1, 1, 0));
    step("len12_c4", sinstr(5'd12), 1'b1, 1'b0, 12'h0);

    step("len31_c1", vinstr(5'd31), 1'b1, 1'b0, ev(1, 1, 2'd0, 5'b11111, 0, 0, 1));
    step("len31_c2", vinstr(5'd31), 1'b1, 1'b0, ev(1, 1, 2'd1, 5'b11111, 1, 0, 0));
    step("len31_c3", vinstr(5'd31), 1'b1, 1'b0, ev(1, 1, 2'd2, 5'b11111, 1, 0, 0));
    step("len31_c4", vinstr(5'd31), 1'b1, 1'b0, ev(0, 1, 2'd3, 5'b11111, 1, 1, 0));
    step("len31_c5", sinstr(5'd0), 1'b0, 1'b0, 12'h0);

    // RegWrite toggles mid-run; the latched value must win
    step("nowr_c1", vinstr(5'd20), 1'b0, 1'b0, ev(1, 0, 2'd0, 5'b11111, 0, 0, 0));
    step("nowr_c2", vinstr(5'd20), 1'b1, 1'b0, ev(1, 0, 2'd1, 5'b11111, 1, 0, 0));
    step("nowr_c3", vinstr(5'd20), 1'b1, 1'b0, ev(1, 0, 2'd2, 5'b11111, 1, 0, 0));
    step("nowr_c4", vinstr(5'd20), 1'b1, 1'b0, ev(0, 0, 2'd3, 5'b11111, 1, 1, 0));
    step("nowr_c5", sinstr(5'd0), 1'b1, 1'b0, 12'h0);

    step("flush_idle", vinstr(5'd3), 1'b1, 1'b1, ev(0, 1, 2'd0, 5'b00111, 0, 1, 0));

    step("flush_c1", vinstr(5'd20), 1'b1, 1'b0, ev(1, 1, 2'd0, 5'b11111, 0, 0, 0));
    step("flush_c2", vinstr(5'd20), 1'b1, 1'b0, ev(1, 1, 2'd1, 5'b11111, 1, 0, 0));
    step("flush_c3", vinstr(5'd20), 1'b1, 1'b1, ev(0, 0, 2'd2, 5'b11111, 1, 0, 0));
    step("flush_c4", sinstr(5'd0), 1'b1, 1'b0, 12'h0);
    chk("flush_state", 32'(dbg_state), 32'h0);

    // flush coinciding with the last pass
    step("flast_c1", vinstr(5'd6), 1'b1, 1'b0, ev(1, 1, 2'd0, 5'b11111, 0, 0, 0));
    step("flast_c2", vinstr(5'd6), 1'b1, 1'b1, ev(0, 0, 2'd1, 5'b00001, 1, 0, 0));
    step("flast_c3", sinstr(5'd0), 1'b1, 1'b0, 12'h0);

    step("rst_c1", vinstr(5'd20), 1'b1, 1'b0, ev(1, 1, 2'd0, 5'b11111, 0, 0, 0));
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_mid_outs", 32'(obs()), 32'h0);
    chk("rst_mid_state", 32'(dbg_state), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    Instr = sinstr(5'd0);
    #1;
    chk("rst_rel_outs", 32'(obs()), 32'h0);
    step("rst_after_idle", sinstr(5'd0), 1'b1, 1'b0, 12'h0);
    chk("rst_after_state", 32'(dbg_state), 32'h0);
    step("rst_fresh_c1", vinstr(5'd7), 1'b0, 1'b0, ev(1, 0, 2'd0, 5'b11111, 0, 0, 0));
    step("rst_fresh_c2", vinstr(5'd7), 1'b0, 1'b0, ev(0, 0, 2'd1, 5'b00011, 1, 1, 0));
    step("rst_fresh_c3", sinstr(5'd0), 1'b0, 1'b0, 12'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
